// File: rtl/regfile_dump_64.sv
// rtl/regfile_dump_64.sv - streams a contiguous range of integer registers out over valid/ready
module regfile_dump_64 #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 5,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
    logic                out_last_q, out_last_d;

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;

        case (state_q)
            IDLE: begin
                rd_addr_d = '0;
                if (start) begin
                    state_d   = READ;
                    rd_addr_d = FIRST_IDX;
                end
            end
            READ: begin
                out_data_d  = rd_data;
                out_idx_d   = rd_addr_q;
                out_last_d  = (rd_addr_q == LAST_IDX);
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    // Increment only below LAST_REG, so the index never wraps.
                    if (out_last_q) begin
                        state_d = DONE;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        state_d   = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            rd_addr_d   = '0;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_regfile_dump_64.sv
// tb/tb_regfile_dump_64.sv - directed self-checking bench for regfile_dump_64
module tb_regfile_dump_64;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, abort, out_ready;
    logic        busy, done, out_valid, out_last;
    logic [4:0]  rd_addr, out_idx;
    logic [63:0] rd_data, out_data;
    logic [63:0] regs [32];

    logic        start5, ready5;
    logic        busy5, done5, valid5, last5;
    logic [4:0]  rd_addr5, idx5;
    logic [63:0] rd_data5, data5;

    int n_pass  = 0;
    int n_total = 0;

    assign rd_data  = regs[rd_addr];
    assign rd_data5 = (rd_addr5 == 5'd5) ? 64'hDEADBEEF : 64'h0;

    regfile_dump_64 dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last)
    );

    regfile_dump_64 #(.FIRST_REG(5), .LAST_REG(5)) dut5 (
        .clk(clk), .reset(reset), .start(start5), .abort(1'b0),
        .busy(busy5), .done(done5), .rd_addr(rd_addr5), .rd_data(rd_data5),
        .out_valid(valid5), .out_ready(ready5), .out_data(data5),
        .out_idx(idx5), .out_last(last5)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Entered in the READ cycle of beat k; returns just after the handshake edge.
    task automatic expect_beat(input int k, input int stall);
        chk("rd_addr_in_read", rd_addr, 64'(k));
        tick;
        chk("beat_valid", out_valid, 1);
        chk("beat_idx", out_idx, 64'(k));
        chk("beat_data", out_data, 64'h1000 + 64'(k));
        chk("beat_last", out_last, 64'(k == 31));
        chk("beat_busy", busy, 1);
        chk("beat_no_done", done, 0);
        if (stall > 0) begin
            out_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                tick;
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, 64'h1000 + 64'(k));
                chk("stall_rd_addr", rd_addr, 64'(k));
            end
            out_ready = 1'b1;
        end
        tick;
        chk("after_hs_valid", out_valid, 0);
    endtask

    task automatic kick;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_busy", busy, 1);
    endtask

    task automatic expect_done;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        tick;
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 64'h1000 + 64'(i);
        reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        start5 = 1'b0; ready5 = 1'b1;
        repeat (2) tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_rd_addr", rd_addr, 0);
        reset = 1'b1;
        tick;

        // Full dump, ready always high
        kick;
        for (int k = 0; k < 32; k++) expect_beat(k, 0);
        expect_done;

        // Backpressure on idx 3
        kick;
        for (int k = 0; k < 32; k++) expect_beat(k, (k == 3) ? 5 : 0);
        expect_done;

        // Abort during idx 10 SEND with ready low
        kick;
        for (int k = 0; k < 10; k++) expect_beat(k, 0);
        tick;
        chk("abort_pre_idx", out_idx, 10);
        chk("abort_pre_valid", out_valid, 1);
        out_ready = 1'b0;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        out_ready = 1'b1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        tick;
        chk("abort_done_later", done, 0);
        kick;
        expect_beat(0, 0);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort2_busy", busy, 0);

        // start pulsed while busy at idx 7
        kick;
        for (int k = 0; k < 7; k++) expect_beat(k, 0);
        start = 1'b1;
        expect_beat(7, 0);
        start = 1'b0;
        for (int k = 8; k < 32; k++) expect_beat(k, 0);
        expect_done;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("single_done", done, 0);
        end

        // Reset during idx 20 SEND
        kick;
        for (int k = 0; k < 20; k++) expect_beat(k, 0);
        tick;
        chk("rst_pre_idx", out_idx, 20);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_idx", out_idx, 0);
        chk("mid_rst_rd_addr", rd_addr, 0);
        kick;
        expect_beat(0, 0);
        abort = 1'b1;
        tick;
        abort = 1'b0;

        // Single-register range FIRST_REG = LAST_REG = 5
        start5 = 1'b1;
        tick;
        start5 = 1'b0;
        chk("p5_rd_addr", rd_addr5, 5);
        chk("p5_busy", busy5, 1);
        tick;
        chk("p5_valid", valid5, 1);
        chk("p5_idx", idx5, 5);
        chk("p5_last", last5, 1);
        chk("p5_data", data5, 64'hDEADBEEF);
        tick;
        chk("p5_done", done5, 1);
        chk("p5_valid_clr", valid5, 0);
        tick;
        chk("p5_done_clr", done5, 0);
        chk("p5_idle", busy5, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_dump_64.md
Name: regfile_dump_64

Overview:
- Read-side debug engine for the 64-bit integer register file.
- On a start pulse it walks a contiguous range of register indices through one spare register-file read port and streams each value out over a valid/ready interface, tagged with its index.
- Sits between the register file and the debug/trace unit; it never writes the register file.

Parameters:
DATA_W, 64, register and stream data width
ADDR_W, 5, register index width
FIRST_REG, 0, first index dumped
LAST_REG, 31, last index dumped; FIRST_REG <= LAST_REG <= 2**ADDR_W-1 is required

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
start  input  1  one-cycle request to begin a dump; sampled only in IDLE
abort  input  1  cancel the dump in progress
busy  output  1  high from the cycle after an accepted start until DONE is left
done  output  1  one-cycle pulse after the final beat's handshake
rd_addr  output  ADDR_W  register-file read index (registered)
rd_data  input  DATA_W  combinational read data for rd_addr
out_valid  output  1  stream beat valid
out_ready  input  1  downstream accepts the beat
out_data  output  DATA_W  register value
out_idx  output  ADDR_W  index of out_data
out_last  output  1  beat carries LAST_REG

Behaviour:
- Everything is sampled on the rising edge of clk; reset low has priority over all other inputs.
- Reset values: state=IDLE; busy=0; done=0; out_valid=0; out_last=0; out_data=0; out_idx=0; rd_addr=0.
- FSM states: IDLE, READ, SEND, DONE.
- IDLE: on start=1, go to READ and set rd_addr=FIRST_REG. Otherwise hold, with rd_addr=0.
- READ (one cycle):
  - capture out_data<=rd_data, out_idx<=rd_addr, out_last<=(rd_addr==LAST_REG);
  - set out_valid<=1 and go to SEND.
- SEND:
  - While out_valid=1 and out_ready=0, hold out_data, out_idx and out_last stable.
  - On handshake (out_valid & out_ready), clear out_valid.
  - If out_idx==LAST_REG, go to DONE.
  - Otherwise set rd_addr<=rd_addr+1 and go to READ.
- DONE (one cycle): done=1 for this cycle only, then go to IDLE. busy=1 in READ, SEND and DONE.
- Timing:
  - start accepted at edge t gives first out_valid=1 at edge t+2.
  - Maximum throughput is one beat per 2 cycles.
  - The final handshake at edge h gives done=1 during the cycle after h.
- Index arithmetic: the rd_addr increment never wraps, because LAST_REG bounds it; this must hold even when LAST_REG=2**ADDR_W-1.
- abort=1 in any non-IDLE state:
  - next state is IDLE; out_valid=0 and busy=0 from the next edge; no done pulse;
  - abort in the same cycle as a handshake still drops the remaining beats, and the handshaked beat counts as delivered.
- start in any state other than IDLE is ignored, with no restart or queuing. start and abort together in IDLE means the start is taken.
- Coherence: each value is the register content during that index's READ cycle. A concurrent register write to an index not yet read is visible in the dump; no snapshot is guaranteed.
- Synchronous reset low mid-dump returns all outputs to reset values at that edge, with no done pulse.

Test Plan:
- Register i preloaded with 64'h1000+i, out_ready tied 1, start at cycle 0:
  - 32 beats at cycles 2,4,...,64, with out_idx 0..31 and out_data 64'h1000..64'h101F;
  - out_last only on idx 31;
  - done high in cycle 65; busy low from cycle 66.
- Backpressure:
  - hold out_ready=0 for 5 cycles on idx 3 → out_valid stays 1 and out_data=64'h1003 is stable throughout;
  - no rd_addr change until the handshake; the next beat (idx 4) is valid 2 cycles after the handshake.
- Abort:
  - abort at the idx 10 SEND cycle with out_ready=0 → out_valid=0 and busy=0 next cycle, no done;
  - a new start then dumps again from idx 0.
- start pulsed while busy at idx 7 → sequence continues unchanged to idx 31, with exactly one done.
- Reset asserted low during the idx 20 SEND cycle → all outputs at reset values next cycle; the next start streams from FIRST_REG.
- Parameters FIRST_REG=LAST_REG=5, reg5=64'hDEADBEEF → single beat with out_idx=5, out_last=1, then a done pulse.
